// File: rtl/crono_timer.sv
// Countdown timer driven by the crono controller: BCD HH:MM:SS preset, start/stop/clear
// commands, one decrement per prescaled tick and a single-cycle crono_end on reaching zero.
module crono_timer #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter logic [7:0]  ADDR_SEC = 8'h41,
  parameter logic [7:0]  ADDR_MIN = 8'h42,
  parameter logic [7:0]  ADDR_HR  = 8'h43,
  parameter logic [7:0]  ADDR_CMD = 8'hF0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       WR_inistop,
  input  logic [7:0] dir,
  input  logic [2:0] inistop,
  input  logic [7:0] wr_data,
  output logic       crono_end,
  output logic       running,
  output logic [7:0] sec_o,
  output logic [7:0] min_o,
  output logic [7:0] hr_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StPause, StEnd} state_e;

  state_e        r_state, w_state_nxt;
  logic [7:0]    r_sec, r_min, r_hr;
  logic [7:0]    w_sec_nxt, w_min_nxt, w_hr_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic          r_running;

  logic w_cmd, w_start, w_stop, w_clear, w_tick, w_time_zero;

  // Clamp a BCD value: bad low digit to 9, then the whole value to lim.
  function automatic logic [7:0] sat_bcd(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] t;
    t = {v[7:4], (v[3:0] > 4'd9) ? 4'd9 : v[3:0]};
    return (t > lim) ? lim : t;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1;
  endfunction

  assign w_cmd       = WR_inistop && (dir == ADDR_CMD);
  assign w_start     = w_cmd && (inistop == 3'b001);
  assign w_stop      = w_cmd && (inistop == 3'b010);
  assign w_clear     = w_cmd && (inistop == 3'b100);
  assign w_tick      = (r_state == StRun) && (r_presc == PW'(TICK_DIV - 1));
  assign w_time_zero = (r_sec == 8'h00) && (r_min == 8'h00) && (r_hr == 8'h00);

  always_comb begin
    w_state_nxt = r_state;
    w_sec_nxt   = r_sec;
    w_min_nxt   = r_min;
    w_hr_nxt    = r_hr;
    w_presc_nxt = r_presc;

    case (r_state)
      StIdle, StPause: begin
        // Resuming from pause keeps the partial second in the prescaler.
        if (w_start && !w_time_zero) begin
          w_state_nxt = StRun;
          if (r_state == StIdle) w_presc_nxt = '0;
        end
        if (WR_inistop) begin
          if (dir == ADDR_SEC)      w_sec_nxt = sat_bcd(wr_data, 8'h59);
          else if (dir == ADDR_MIN) w_min_nxt = sat_bcd(wr_data, 8'h59);
          else if (dir == ADDR_HR)  w_hr_nxt  = sat_bcd(wr_data, 8'h23);
        end
      end
      StRun: begin
        // A stop freezes everything, including a tick landing in the same cycle.
        if (w_stop) begin
          w_state_nxt = StPause;
        end else if (w_tick) begin
          w_presc_nxt = '0;
          if (r_sec != 8'h00) begin
            w_sec_nxt = bcd_dec(r_sec);
          end else if (r_min != 8'h00) begin
            w_sec_nxt = 8'h59;
            w_min_nxt = bcd_dec(r_min);
          end else if (r_hr != 8'h00) begin
            w_sec_nxt = 8'h59;
            w_min_nxt = 8'h59;
            w_hr_nxt  = bcd_dec(r_hr);
          end
          if ((w_sec_nxt == 8'h00) && (w_min_nxt == 8'h00) && (w_hr_nxt == 8'h00)) begin
            w_state_nxt = StEnd;
          end
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
      StEnd:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase

    if (w_clear) begin
      w_state_nxt = StIdle;
      w_sec_nxt   = 8'h00;
      w_min_nxt   = 8'h00;
      w_hr_nxt    = 8'h00;
      w_presc_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_sec     <= 8'h00;
      r_min     <= 8'h00;
      r_hr      <= 8'h00;
      r_presc   <= '0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sec     <= w_sec_nxt;
      r_min     <= w_min_nxt;
      r_hr      <= w_hr_nxt;
      r_presc   <= w_presc_nxt;
      r_running <= (w_state_nxt == StRun);
    end
  end

  assign crono_end = (r_state == StEnd);
  assign running   = r_running;
  assign sec_o     = r_sec;
  assign min_o     = r_min;
  assign hr_o      = r_hr;

endmodule

// File: tb/tb_crono_timer.sv
// Bench for crono_timer: directed scenarios then random traffic, each cycle compared against
// a model that keeps the remaining time as a plain count of seconds.
module tb_crono_timer;

  localparam int TICK = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_END = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       WR_inistop;
  logic [7:0] dir;
  logic [2:0] inistop;
  logic [7:0] wr_data;
  logic       crono_end, running;
  logic [7:0] sec_o, min_o, hr_o;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: remaining time in seconds, cycles elapsed within the current second, mode.
  int m_secs  = 0;
  int m_phase = 0;
  int m_mode  = M_IDLE;

  crono_timer #(.TICK_DIV(TICK)) dut (
    .clk        (clk),
    .reset      (reset),
    .WR_inistop (WR_inistop),
    .dir        (dir),
    .inistop    (inistop),
    .wr_data    (wr_data),
    .crono_end  (crono_end),
    .running    (running),
    .sec_o      (sec_o),
    .min_o      (min_o),
    .hr_o       (hr_o)
  );

  always #5 clk = ~clk;

  function automatic int sat_dec(input logic [7:0] v, input int lim);
    int hi, lo, val;
    hi  = int'(v[7:4]);
    lo  = int'(v[3:0]);
    if (lo > 9) lo = 9;
    val = hi * 10 + lo;
    return (val > lim) ? lim : val;
  endfunction

  function automatic logic [7:0] to_bcd(input int d);
    return 8'(((d / 10) << 4) | (d % 10));
  endfunction

  task automatic model_reset();
    m_secs  = 0;
    m_phase = 0;
    m_mode  = M_IDLE;
  endtask

  task automatic model_step(input logic we, input logic [7:0] d, input logic [2:0] c,
                            input logic [7:0] data);
    int h, m, s;
    h = m_secs / 3600;
    m = (m_secs / 60) % 60;
    s = m_secs % 60;
    if (we && d == 8'hF0 && c == 3'b100) begin
      model_reset();
    end else if (m_mode == M_END) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_RUN) begin
      if (we && d == 8'hF0 && c == 3'b010) begin
        m_mode = M_PAUSE;
      end else begin
        m_phase++;
        if (m_phase == TICK) begin
          m_phase = 0;
          m_secs--;
          if (m_secs == 0) m_mode = M_END;
        end
      end
    end else begin
      if (we && d == 8'hF0 && c == 3'b001 && m_secs > 0) begin
        if (m_mode == M_IDLE) m_phase = 0;
        m_mode = M_RUN;
      end
      if (we && d == 8'h41) s = sat_dec(data, 59);
      if (we && d == 8'h42) m = sat_dec(data, 59);
      if (we && d == 8'h43) h = sat_dec(data, 23);
      m_secs = h * 3600 + m * 60 + s;
    end
  endtask

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    cmp("running",   {7'd0, running},   {7'd0, m_mode == M_RUN});
    cmp("crono_end", {7'd0, crono_end}, {7'd0, m_mode == M_END});
    cmp("sec_o", sec_o, to_bcd(m_secs % 60));
    cmp("min_o", min_o, to_bcd((m_secs / 60) % 60));
    cmp("hr_o",  hr_o,  to_bcd(m_secs / 3600));
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model and compare.
  task automatic cyc(input logic we, input logic [7:0] d, input logic [2:0] c,
                     input logic [7:0] data);
    WR_inistop = we;
    dir        = d;
    inistop    = c;
    wr_data    = data;
    @(posedge clk);
    model_step(we, d, c, data);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 3'b000, 8'h00);
  endtask

  task automatic wr(input logic [7:0] d, input logic [7:0] data);
    cyc(1'b1, d, 3'b000, data);
  endtask

  task automatic cmd(input logic [2:0] c);
    cyc(1'b1, 8'hF0, c, 8'h00);
  endtask

  initial begin
    reset      = 1'b1;
    WR_inistop = 1'b0;
    dir        = 8'h00;
    inistop    = 3'b000;
    wr_data    = 8'h00;
    #1;
    check_all();
    #9;
    reset = 1'b0;

    // Basic countdown to completion.
    wr(8'h41, 8'h03);
    cmd(3'b001);
    idle(16);

    // Borrow across hours.
    wr(8'h43, 8'h01);
    wr(8'h42, 8'h00);
    wr(8'h41, 8'h00);
    cmd(3'b001);
    idle(6);
    cmd(3'b100);

    // Pause keeps the partial second.
    wr(8'h41, 8'h05);
    cmd(3'b001);
    idle(6);
    cmd(3'b010);
    idle(3);
    cmd(3'b001);
    idle(5);
    cmd(3'b100);

    // Saturation, and writes ignored while running.
    wr(8'h41, 8'h7A);
    wr(8'h43, 8'h31);
    wr(8'h42, 8'hA5);
    cmd(3'b001);
    wr(8'h41, 8'h10);
    idle(2);
    cmd(3'b100);

    // Start with zero time, then clear mid-run.
    cmd(3'b001);
    idle(3);
    wr(8'h41, 8'h03);
    cmd(3'b001);
    idle(4);
    cmd(3'b100);
    idle(2);

    // Stop coinciding with a tick.
    wr(8'h41, 8'h02);
    cmd(3'b001);
    idle(3);
    cmd(3'b010);
    idle(3);
    cmd(3'b001);
    idle(10);

    // Reset while in the end cycle.
    wr(8'h41, 8'h01);
    cmd(3'b001);
    for (int i = 0; i < 8 && m_mode != M_END; i++) idle(1);
    cmp("reached_end", {7'd0, crono_end}, 8'd1);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] d, data;
      int sel;
      sel = $urandom_range(0, 4);
      case (sel)
        0:       d = 8'h41;
        1:       d = 8'h42;
        2:       d = 8'h43;
        3:       d = 8'hF0;
        default: d = 8'($urandom_range(0, 255));
      endcase
      data = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      cyc($urandom_range(0, 2) == 0, d, 3'($urandom_range(0, 7)), data);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
